id_ex_forward_stage: RTL
========================

Name: id_ex_forward_stage

Overview:
- ID/EX pipeline register, directly downstream of data_bypass_controller in the redirection pipeline with BTB.
- Consumes R1_Forward, R2_Forward and Stall from data_bypass_controller, plus BranchCLR.
- Each cycle it selects the forwarded ID-stage operands and latches them into EX together with the ID control bundle, IR and PC.
- On a load-use Stall or a branch redirect it inserts a bubble, and it counts the bubbles inserted.

Parameters:
- CTRL_W, 16, width of the decoded ID control bundle carried into EX.
- CNT_W, 32, width of the bubble/stall statistics counters.

Ports:
- CLK  in  1  pipeline clock; all state updates on the rising edge.
- RST  in  1  synchronous, active-high reset.
- ID_PC  in  32  PC of the instruction in ID.
- ID_IR  in  32  instruction in ID.
- ID_Ctrl  in  CTRL_W  decoded control bundle; bit 0 = RegWrite.
- ID_R1  in  32  register-file read data, port 1.
- ID_R2  in  32  register-file read data, port 2.
- ID_Imm  in  32  extended immediate.
- R1_Forward  in  2  operand 1 select: 0 regfile, 1 MEM ALU result, 2 MEM load data, 3 EX ALU result.
- R2_Forward  in  2  operand 2 select, same encoding.
- Stall  in  1  load-use hazard from the bypass controller.
- BranchCLR  in  1  branch/BTB mispredict flush.
- EX_AluResult  in  32  ALU result of the instruction currently in EX.
- MEM_AluResult  in  32  ALU result held in MEM.
- MEM_MemData  in  32  data-memory read data in MEM.
- EX_PC  out  32  latched PC.
- EX_IR  out  32  latched IR; 0 (nop) for a bubble.
- EX_Ctrl  out  CTRL_W  latched control; all-zero for a bubble.
- EX_A  out  32  latched forwarded operand 1.
- EX_B  out  32  latched forwarded operand 2.
- EX_Imm  out  32  latched immediate.
- EX_Valid  out  1  1 = real instruction in EX, 0 = bubble.
- PC_ID_Hold  out  1  combinational = Stall & ~BranchCLR; freezes PC and IF/ID.
- BubbleCnt  out  CNT_W  total bubbles inserted.
- StallCnt  out  CNT_W  bubbles caused by Stall only.

Behaviour:
- Reset:
  - All EX_* outputs = 0 and EX_Valid = 0.
  - BubbleCnt = 0 and StallCnt = 0.
  - RST has priority over every other input.
- Operand mux, combinational in ID:
  - opA = mux(R1_Forward; ID_R1, MEM_AluResult, MEM_MemData, EX_AluResult).
  - opB = mux(R2_Forward; ID_R2, MEM_AluResult, MEM_MemData, EX_AluResult).
- Latency: 1 cycle from ID inputs to EX_* outputs.
- Per-edge priority (exactly one branch applies):
  1. RST: reset as above.
  2. BranchCLR = 1: bubble (IR = 0, Ctrl = 0, A = B = Imm = 0, PC = 0, Valid = 0). BubbleCnt +1; StallCnt unchanged. A simultaneous Stall is ignored, because the stalled instruction is on the wrong path.
  3. Stall = 1: bubble as in 2. BubbleCnt +1, StallCnt +1. The forward selects are ignored that cycle.
  4. Otherwise: latch ID_PC, ID_IR, ID_Ctrl, opA, opB, ID_Imm; Valid = 1.
- State machine: EX_Valid is a 2-state register, VALID / BUBBLE.
  - Any edge with BranchCLR or Stall goes to BUBBLE.
  - Any other non-reset edge goes to VALID.
- Back-to-back Stall cycles: one bubble per cycle, and the counters increment every cycle.
- Counters wrap modulo 2^CNT_W with no saturation.
- Reset asserted mid-stall: the next edge clears the state. PC_ID_Hold still follows its combinational equation during reset.

Optional Feature:
- Macro: ID_EX_PERF_CNT_EN.
- Defined: BubbleCnt and StallCnt are implemented as specified.
- Undefined: no counter flops are instantiated, and both outputs are tied to constant 0. All other behaviour is unchanged.

Test Plan:
- Reset: RST = 1 for 2 cycles -> EX_Valid = 0, EX_IR = 0, BubbleCnt = 0, StallCnt = 0.
- Forward select sweep: ID_R1 = 0x11, MEM_AluResult = 0x22, MEM_MemData = 0x33, EX_AluResult = 0x44; R1_Forward = 0..3 on consecutive cycles -> EX_A = 0x11, 0x22, 0x33, 0x44 one cycle later. Repeat on R2/EX_B.
- Load-use stall: Stall = 1 for 1 cycle with ID_IR = 0x00851020 -> bubble (EX_IR = 0, EX_Valid = 0), PC_ID_Hold = 1, BubbleCnt = 1, StallCnt = 1. Next cycle with Stall = 0 -> EX_IR = 0x00851020, EX_Valid = 1.
- Flush beats stall: BranchCLR = 1 and Stall = 1 together -> bubble, PC_ID_Hold = 0, BubbleCnt +1, StallCnt unchanged.
- Counter wrap (CNT_W = 4): 16 consecutive Stall cycles -> StallCnt returns to 0.
- Macro off: with ID_EX_PERF_CNT_EN undefined, 5 stalls -> BubbleCnt = 0 and StallCnt = 0, while EX_* behaviour is identical to the macro-on build.

Source files
------------

// File: rtl/id_ex_forward_stage.sv
// ID/EX pipeline register with operand forwarding mux, bubble insertion and bubble statistics.
// Optional counters enabled by defining ID_EX_PERF_CNT_EN; otherwise BubbleCnt/StallCnt read 0.
`default_nettype none

module id_ex_forward_stage #(
    parameter int CTRL_W = 16,
    parameter int CNT_W  = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [31:0]       ID_PC,
    input  logic [31:0]       ID_IR,
    input  logic [CTRL_W-1:0] ID_Ctrl,
    input  logic [31:0]       ID_R1,
    input  logic [31:0]       ID_R2,
    input  logic [31:0]       ID_Imm,
    input  logic [1:0]        R1_Forward,
    input  logic [1:0]        R2_Forward,
    input  logic              Stall,
    input  logic              BranchCLR,
    input  logic [31:0]       EX_AluResult,
    input  logic [31:0]       MEM_AluResult,
    input  logic [31:0]       MEM_MemData,
    output logic [31:0]       EX_PC,
    output logic [31:0]       EX_IR,
    output logic [CTRL_W-1:0] EX_Ctrl,
    output logic [31:0]       EX_A,
    output logic [31:0]       EX_B,
    output logic [31:0]       EX_Imm,
    output logic              EX_Valid,
    output logic              PC_ID_Hold,
    output logic [CNT_W-1:0]  BubbleCnt,
    output logic [CNT_W-1:0]  StallCnt
);

    typedef enum logic [0:0] {
        ST_BUBBLE = 1'b0,
        ST_VALID  = 1'b1
    } state_t;

    state_t      state, state_next;
    logic        bubble;
    logic [31:0] op_a, op_b;

    assign bubble     = BranchCLR | Stall;
    // A flushed instruction is on the wrong path, so the flush releases the hold.
    assign PC_ID_Hold = Stall & ~BranchCLR;

    always_comb begin
        op_a = ID_R1;
        case (R1_Forward)
            2'd0: op_a = ID_R1;
            2'd1: op_a = MEM_AluResult;
            2'd2: op_a = MEM_MemData;
            2'd3: op_a = EX_AluResult;
            default: op_a = ID_R1;
        endcase
    end

    always_comb begin
        op_b = ID_R2;
        case (R2_Forward)
            2'd0: op_b = ID_R2;
            2'd1: op_b = MEM_AluResult;
            2'd2: op_b = MEM_MemData;
            2'd3: op_b = EX_AluResult;
            default: op_b = ID_R2;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST || bubble) begin
            EX_PC   <= '0;
            EX_IR   <= '0;
            EX_Ctrl <= '0;
            EX_A    <= '0;
            EX_B    <= '0;
            EX_Imm  <= '0;
        end else begin
            EX_PC   <= ID_PC;
            EX_IR   <= ID_IR;
            EX_Ctrl <= ID_Ctrl;
            EX_A    <= op_a;
            EX_B    <= op_b;
            EX_Imm  <= ID_Imm;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= ST_BUBBLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (bubble) begin
            state_next = ST_BUBBLE;
        end else begin
            state_next = ST_VALID;
        end
    end

    assign EX_Valid = (state == ST_VALID);

`ifdef ID_EX_PERF_CNT_EN
    logic [CNT_W-1:0] bubble_cnt, stall_cnt;

    // Counters wrap freely; stall-only bubbles exclude flush cycles.
    always_ff @(posedge CLK) begin
        if (RST) begin
            bubble_cnt <= '0;
            stall_cnt  <= '0;
        end else begin
            if (bubble) begin
                bubble_cnt <= bubble_cnt + CNT_W'(1);
            end
            if (PC_ID_Hold) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
        end
    end

    assign BubbleCnt = bubble_cnt;
    assign StallCnt  = stall_cnt;
`else
    assign BubbleCnt = '0;
    assign StallCnt  = '0;
`endif

endmodule

`default_nettype wire
